// File: rtl/taxi_axi_pipe_pkg.sv
// Shared types for the AXI read-path pipeline: register stage flavours and chain limits.
package taxi_axi_pipe_pkg;

  typedef enum logic [1:0] {
    REG_BYPASS = 2'd0,
    REG_SIMPLE = 2'd1,
    REG_SKID   = 2'd2
  } reg_type_e;

  localparam int MAX_STAGES = 8;

  // A bypass channel still instantiates one (wire-only) stage to keep the chain uniform.
  function automatic int eff_stages(input int reg_type, input int stages);
    return (reg_type == 0) ? 1 : stages;
  endfunction

endpackage

// File: rtl/taxi_axi_if.sv
// AXI4 read-channel interface; rd_slv faces the requester, rd_mst faces the completer.
interface taxi_axi_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int STRB_W    = DATA_W / 8,
  parameter int ID_W      = 8,
  parameter bit ARUSER_EN = 1'b0,
  parameter int ARUSER_W  = 1,
  parameter bit RUSER_EN  = 1'b0,
  parameter int RUSER_W   = 1
) ();
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport rd_slv (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport rd_mst (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
endinterface

// File: rtl/taxi_axi_pipe_stage.sv
// One valid/ready register slice: wire, half-rate simple register, or full-rate skid register.
module taxi_axi_pipe_stage
  import taxi_axi_pipe_pkg::*;
#(
  parameter int        W        = 8,
  parameter reg_type_e REG_TYPE = REG_SKID
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  if (REG_TYPE == REG_BYPASS) begin : g_bypass
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;

  end else if (REG_TYPE == REG_SIMPLE) begin : g_simple
    logic [W-1:0] data_q;
    logic         vld_q;

    // Only accepts into an empty slot, so at most one beat every two cycles.
    assign in_ready  = !vld_q && !rst;
    assign out_data  = data_q;
    assign out_valid = vld_q;

    always_ff @(posedge clk) begin
      if (in_valid && in_ready) data_q <= in_data;
      if (rst)                        vld_q <= 1'b0;
      else if (in_valid && in_ready)  vld_q <= 1'b1;
      else if (out_ready)             vld_q <= 1'b0;
    end

  end else begin : g_skid
    logic [W-1:0] main_q, skid_q;
    logic         main_v, skid_v, rdy_q;
    logic         main_v_n, skid_v_n, load_in, load_skid, store_skid;
    logic         in_hs;

    assign in_hs     = in_valid && rdy_q;
    assign in_ready  = rdy_q;
    assign out_data  = main_q;
    assign out_valid = main_v;

    always_comb begin
      main_v_n   = main_v;
      skid_v_n   = skid_v;
      load_in    = 1'b0;
      load_skid  = 1'b0;
      store_skid = 1'b0;
      if (out_ready || !main_v) begin
        if (skid_v) begin
          load_skid = 1'b1;
          main_v_n  = 1'b1;
          skid_v_n  = 1'b0;
        end else if (in_hs) begin
          load_in  = 1'b1;
          main_v_n = 1'b1;
        end else begin
          main_v_n = 1'b0;
        end
      end else if (in_hs) begin
        // Output stalled: park the beat accepted on the registered ready.
        store_skid = 1'b1;
        skid_v_n   = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (load_in)         main_q <= in_data;
      else if (load_skid)  main_q <= skid_q;
      if (store_skid)      skid_q <= in_data;
      if (rst) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        rdy_q  <= 1'b0;
      end else begin
        main_v <= main_v_n;
        skid_v <= skid_v_n;
        rdy_q  <= !skid_v_n;
      end
    end
  end

endmodule

// File: rtl/taxi_axi_pipe_rd.sv
// AXI4 read-path pipeline: independent register chains on AR and R.
// Define TAXI_AXI_PIPE_RD_LIMIT_EN to cap outstanding bursts at MAX_OUTSTANDING.
module taxi_axi_pipe_rd
  import taxi_axi_pipe_pkg::*;
#(
  parameter int AR_REG_TYPE     = 2,
  parameter int R_REG_TYPE      = 2,
  parameter int AR_STAGES       = 1,
  parameter int R_STAGES        = 1,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic clk,
  input  logic rst,
  taxi_axi_if.rd_slv s_axi_rd,
  taxi_axi_if.rd_mst m_axi_rd
);

  localparam int ID_W     = s_axi_rd.ID_W;
  localparam int ADDR_W   = s_axi_rd.ADDR_W;
  localparam int DATA_W   = s_axi_rd.DATA_W;
  localparam int ARUSER_W = s_axi_rd.ARUSER_W;
  localparam int RUSER_W  = m_axi_rd.RUSER_W;
  localparam bit ARUSER_EN = s_axi_rd.ARUSER_EN && m_axi_rd.ARUSER_EN;
  localparam bit RUSER_EN  = s_axi_rd.RUSER_EN && m_axi_rd.RUSER_EN;
  localparam int AR_N = eff_stages(AR_REG_TYPE, AR_STAGES);
  localparam int R_N  = eff_stages(R_REG_TYPE, R_STAGES);

  if (s_axi_rd.DATA_W != m_axi_rd.DATA_W || s_axi_rd.STRB_W != m_axi_rd.STRB_W) begin : g_chk_data
    $fatal(1, "taxi_axi_pipe_rd: DATA_W/STRB_W differ between interfaces");
  end
  if ((ARUSER_EN && s_axi_rd.ARUSER_W != m_axi_rd.ARUSER_W) ||
      (RUSER_EN && s_axi_rd.RUSER_W != m_axi_rd.RUSER_W)) begin : g_chk_user
    $fatal(1, "taxi_axi_pipe_rd: USER widths differ between interfaces");
  end
  if (AR_REG_TYPE > 2 || R_REG_TYPE > 2 || AR_N < 1 || AR_N > MAX_STAGES ||
      R_N < 1 || R_N > MAX_STAGES) begin : g_chk_cfg
    $fatal(1, "taxi_axi_pipe_rd: bad register type or stage count");
  end

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [ARUSER_W-1:0] user;
  } ar_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [DATA_W-1:0]  data;
    logic [1:0]         resp;
    logic               last;
    logic [RUSER_W-1:0] user;
  } r_t;

  localparam int AR_W = $bits(ar_t);
  localparam int R_W  = $bits(r_t);

  ar_t ar_in, ar_out;
  r_t  r_in, r_out;
  logic [AR_W-1:0] ar_d [AR_N+1];
  logic [AR_N:0]   ar_v, ar_r;
  logic [R_W-1:0]  r_d [R_N+1];
  logic [R_N:0]    r_v, r_r;
  logic            lim_block;

  // AR: s -> m
  assign ar_in = '{id: s_axi_rd.arid, addr: s_axi_rd.araddr, len: s_axi_rd.arlen,
                   size: s_axi_rd.arsize, burst: s_axi_rd.arburst, lock: s_axi_rd.arlock,
                   cache: s_axi_rd.arcache, prot: s_axi_rd.arprot, qos: s_axi_rd.arqos,
                   region: s_axi_rd.arregion, user: ARUSER_EN ? s_axi_rd.aruser : '0};
  assign ar_d[0]          = ar_in;
  assign ar_v[0]          = s_axi_rd.arvalid;
  assign s_axi_rd.arready = ar_r[0];

  for (genvar i = 0; i < AR_N; i++) begin : g_ar
    taxi_axi_pipe_stage #(.W(AR_W), .REG_TYPE(reg_type_e'(AR_REG_TYPE))) u_stage (
      .clk(clk), .rst(rst),
      .in_data(ar_d[i]), .in_valid(ar_v[i]), .in_ready(ar_r[i]),
      .out_data(ar_d[i+1]), .out_valid(ar_v[i+1]), .out_ready(ar_r[i+1])
    );
  end

  // The limiter gates only the last hop; the held beat stays in the final stage.
  assign ar_out            = ar_t'(ar_d[AR_N]);
  assign m_axi_rd.arvalid  = ar_v[AR_N] && !lim_block;
  assign ar_r[AR_N]        = m_axi_rd.arready && !lim_block;
  assign m_axi_rd.arid     = ar_out.id;
  assign m_axi_rd.araddr   = ar_out.addr;
  assign m_axi_rd.arlen    = ar_out.len;
  assign m_axi_rd.arsize   = ar_out.size;
  assign m_axi_rd.arburst  = ar_out.burst;
  assign m_axi_rd.arlock   = ar_out.lock;
  assign m_axi_rd.arcache  = ar_out.cache;
  assign m_axi_rd.arprot   = ar_out.prot;
  assign m_axi_rd.arqos    = ar_out.qos;
  assign m_axi_rd.arregion = ar_out.region;
  assign m_axi_rd.aruser   = ARUSER_EN ? ar_out.user : '0;

  // R: m -> s
  assign r_in = '{id: m_axi_rd.rid, data: m_axi_rd.rdata, resp: m_axi_rd.rresp,
                  last: m_axi_rd.rlast, user: RUSER_EN ? m_axi_rd.ruser : '0};
  assign r_d[0]          = r_in;
  assign r_v[0]          = m_axi_rd.rvalid;
  assign m_axi_rd.rready = r_r[0];

  for (genvar i = 0; i < R_N; i++) begin : g_r
    taxi_axi_pipe_stage #(.W(R_W), .REG_TYPE(reg_type_e'(R_REG_TYPE))) u_stage (
      .clk(clk), .rst(rst),
      .in_data(r_d[i]), .in_valid(r_v[i]), .in_ready(r_r[i]),
      .out_data(r_d[i+1]), .out_valid(r_v[i+1]), .out_ready(r_r[i+1])
    );
  end

  assign r_out           = r_t'(r_d[R_N]);
  assign s_axi_rd.rvalid = r_v[R_N];
  assign r_r[R_N]        = s_axi_rd.rready;
  assign s_axi_rd.rid    = r_out.id;
  assign s_axi_rd.rdata  = r_out.data;
  assign s_axi_rd.rresp  = r_out.resp;
  assign s_axi_rd.rlast  = r_out.last;
  assign s_axi_rd.ruser  = RUSER_EN ? r_out.user : '0;

`ifdef TAXI_AXI_PIPE_RD_LIMIT_EN
  logic [7:0] outstanding;
  logic       ar_hs, r_done;

  assign ar_hs     = m_axi_rd.arvalid && m_axi_rd.arready;
  assign r_done    = m_axi_rd.rvalid && m_axi_rd.rready && m_axi_rd.rlast;
  assign lim_block = (outstanding == 8'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (rst) outstanding <= 8'd0;
    else     outstanding <= outstanding + {7'd0, ar_hs} - {7'd0, r_done};
  end
`else
  assign lim_block = 1'b0;
`endif

endmodule

// File: tb/tb_taxi_axi_pipe_rd.sv
// Directed bench for taxi_axi_pipe_rd: skid/simple/bypass chains, backpressure, reset, limiter.
module tb_taxi_axi_pipe_rd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  taxi_axi_if #(.ID_W(4), .ARUSER_EN(1), .ARUSER_W(4), .RUSER_EN(1), .RUSER_W(4))
    sa_a(), sa_b(), ma_b(), sa_c(), ma_c();
  taxi_axi_if #(.ID_W(4), .ARUSER_EN(0), .ARUSER_W(4), .RUSER_EN(1), .RUSER_W(4)) ma_a();

  // A: AR skid x1, R simple x1.  B: AR simple x2, R skid x3, limit 2.  C: bypass.
  taxi_axi_pipe_rd #(.AR_REG_TYPE(2), .R_REG_TYPE(1), .AR_STAGES(1), .R_STAGES(1), .MAX_OUTSTANDING(16))
    dut_a (.clk(clk), .rst(rst), .s_axi_rd(sa_a), .m_axi_rd(ma_a));
  taxi_axi_pipe_rd #(.AR_REG_TYPE(1), .R_REG_TYPE(2), .AR_STAGES(2), .R_STAGES(3), .MAX_OUTSTANDING(2))
    dut_b (.clk(clk), .rst(rst), .s_axi_rd(sa_b), .m_axi_rd(ma_b));
  taxi_axi_pipe_rd #(.AR_REG_TYPE(0), .R_REG_TYPE(0), .AR_STAGES(1), .R_STAGES(1), .MAX_OUTSTANDING(16))
    dut_c (.clk(clk), .rst(rst), .s_axi_rd(sa_c), .m_axi_rd(ma_c));

`define IDLE_S(s) begin s.arid = '0; s.araddr = '0; s.arlen = '0; s.arsize = '0; s.arburst = '0; \
  s.arlock = 1'b0; s.arcache = '0; s.arprot = '0; s.arqos = '0; s.arregion = '0; s.aruser = '0; \
  s.arvalid = 1'b0; s.rready = 1'b0; end
`define IDLE_M(m) begin m.arready = 1'b0; m.rid = '0; m.rdata = '0; m.rresp = '0; m.rlast = 1'b0; \
  m.ruser = '0; m.rvalid = 1'b0; end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E37_79B9;
  endfunction

  int mbeat, obeat, scnt, mcnt;
  logic mhs, shs, prev_stall;
  logic [31:0] prev_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    `IDLE_S(sa_a) `IDLE_S(sa_b) `IDLE_S(sa_c)
    `IDLE_M(ma_a) `IDLE_M(ma_b) `IDLE_M(ma_c)

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_arvalid", ma_a.arvalid, 0);
    chk("rst_a_rvalid", sa_a.rvalid, 0);
    chk("rst_a_skid_arready", sa_a.arready, 0);
    chk("rst_a_simple_rready", ma_a.rready, 0);
    chk("rst_b_rvalid", sa_b.rvalid, 0);
    chk("rst_b_skid_rready", ma_b.rready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_a_skid_arready", sa_a.arready, 1);
    chk("post_rst_b_skid_rready", ma_b.rready, 1);
    chk("post_rst_a_simple_rready", ma_a.rready, 1);

    // 1: AR skid, 16 back-to-back requests, one cycle latency, no gaps
    ma_a.arready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      sa_a.arvalid = (c < 16);
      sa_a.araddr  = 32'(c) * 32'h40;
      sa_a.arid    = 4'(c);
      sa_a.arlen   = 8'd3;
      sa_a.aruser  = 4'hA;
      @(negedge clk);
      if (c < 16) chk("t1_s_arready", sa_a.arready, 1);
      if (c == 0 || c == 17) chk("t1_m_arvalid_idle", ma_a.arvalid, 0);
      else begin
        chk("t1_m_arvalid", ma_a.arvalid, 1);
        chk("t1_m_araddr", ma_a.araddr, 64'((c - 1) * 'h40));
        chk("t1_m_arid", ma_a.arid, 64'((c - 1) % 16));
        chk("t1_m_arlen", ma_a.arlen, 3);
        chk("t1_m_aruser_off", ma_a.aruser, 0);
      end
    end
    sa_a.arvalid = 1'b0;

    // 2: R simple, 8-beat stream leaves on odd cycles
    sa_a.rready = 1'b1;
    mbeat = 0; obeat = 0; mhs = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (mhs) mbeat++;
      ma_a.rvalid = (mbeat < 8);
      ma_a.rdata  = 32'hA0 + 32'(mbeat);
      ma_a.rlast  = (mbeat == 7);
      ma_a.rid    = 4'h5;
      @(negedge clk);
      mhs = ma_a.rvalid && ma_a.rready;
      if (sa_a.rvalid) begin
        chk("t2_beat_cycle", c, 2 * obeat + 1);
        chk("t2_rdata", sa_a.rdata, 'hA0 + obeat);
        chk("t2_rlast", sa_a.rlast, obeat == 7);
        chk("t2_rid", sa_a.rid, 5);
        obeat++;
      end
    end
    chk("t2_beat_count", obeat, 8);
    ma_a.rvalid = 1'b0; ma_a.rlast = 1'b0;

    // 4: bypass, zero latency both directions
    @(posedge clk); #1;
    sa_c.arvalid = 1'b1; sa_c.araddr = 32'hDEAD_BEE0; sa_c.aruser = 4'h9; ma_c.arready = 1'b0;
    @(negedge clk);
    chk("t4_arvalid", ma_c.arvalid, 1);
    chk("t4_araddr", ma_c.araddr, 32'hDEAD_BEE0);
    chk("t4_aruser", ma_c.aruser, 4'h9);
    chk("t4_arready_lo", sa_c.arready, 0);
    @(posedge clk); #1 ma_c.arready = 1'b1;
    @(negedge clk);
    chk("t4_arready_hi", sa_c.arready, 1);
    @(posedge clk); #1 sa_c.arvalid = 1'b0;
    @(negedge clk);
    chk("t4_arvalid_drop", ma_c.arvalid, 0);
    @(posedge clk); #1;
    ma_c.rvalid = 1'b1; ma_c.rdata = 32'h1234_5678; ma_c.ruser = 4'h3; ma_c.rlast = 1'b1; sa_c.rready = 1'b0;
    @(negedge clk);
    chk("t4_rvalid", sa_c.rvalid, 1);
    chk("t4_rdata", sa_c.rdata, 32'h1234_5678);
    chk("t4_ruser", sa_c.ruser, 4'h3);
    chk("t4_rready_lo", ma_c.rready, 0);
    @(posedge clk); #1 sa_c.rready = 1'b1;
    @(negedge clk);
    chk("t4_rready_hi", ma_c.rready, 1);
    @(posedge clk); #1 ma_c.rvalid = 1'b0;

    // 3a: R skid x3, full rate, latency 3
    sa_b.rready = 1'b1;
    mbeat = 0; obeat = 0; mhs = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (mhs) mbeat++;
      ma_b.rvalid = (mbeat < 8);
      ma_b.rdata  = 32'hB0 + 32'(mbeat);
      ma_b.rlast  = (mbeat == 7);
      @(negedge clk);
      mhs = ma_b.rvalid && ma_b.rready;
      if (sa_b.rvalid) begin
        chk("t3a_beat_cycle", c, 3 + obeat);
        chk("t3a_rdata", sa_b.rdata, 'hB0 + obeat);
        chk("t3a_rlast", sa_b.rlast, obeat == 7);
        obeat++;
      end
    end
    chk("t3a_beat_count", obeat, 8);

    // 3: R skid x3, 256 beats under random backpressure
    mbeat = 0; obeat = 0; mhs = 1'b0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 3000 && obeat < 256; c++) begin
      @(posedge clk); #1;
      if (mhs) mbeat++;
      ma_b.rvalid = (mbeat < 256);
      ma_b.rdata  = pat(mbeat);
      ma_b.rlast  = (mbeat % 4 == 3);
      sa_b.rready = 1'($urandom_range(0, 1));
      @(negedge clk);
      mhs = ma_b.rvalid && ma_b.rready;
      if (prev_stall) begin
        chk("t3_hold_valid", sa_b.rvalid, 1);
        chk("t3_hold_data", sa_b.rdata, prev_data);
      end
      if (sa_b.rvalid && sa_b.rready) begin
        chk("t3_rdata", sa_b.rdata, pat(obeat));
        chk("t3_rlast", sa_b.rlast, obeat % 4 == 3);
        obeat++;
      end
      prev_stall = sa_b.rvalid && !sa_b.rready;
      prev_data  = sa_b.rdata;
    end
    chk("t3_beat_count", obeat, 256);
    ma_b.rvalid = 1'b0; ma_b.rlast = 1'b0; sa_b.rready = 1'b1;

    // 5: one-cycle reset while a burst is in flight
    sa_a.rready = 1'b0;
    @(posedge clk); #1;
    ma_a.rvalid = 1'b1; ma_a.rdata = 32'hC0; ma_a.rlast = 1'b0;
    @(negedge clk);
    chk("t5_first_accept", ma_a.rready, 1);
    @(posedge clk); #1 ma_a.rdata = 32'hC1;
    @(negedge clk);
    chk("t5_stalled_valid", sa_a.rvalid, 1);
    chk("t5_stalled_data", sa_a.rdata, 32'hC0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ma_a.rvalid = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_cleared", sa_a.rvalid, 0);
    sa_a.rready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_no_stale", sa_a.rvalid, 0);
    end

    // 6: outstanding limit on B (MAX_OUTSTANDING=2), R withheld
    ma_b.arready = 1'b1;
    scnt = 0; mcnt = 0; shs = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (shs) scnt++;
      sa_b.arvalid = (scnt < 4);
      sa_b.araddr  = 32'(scnt) << 8;
      @(negedge clk);
      shs = sa_b.arvalid && sa_b.arready;
      if (ma_b.arvalid && ma_b.arready) begin
        chk("t6_m_araddr_order", ma_b.araddr, 64'(mcnt) << 8);
        mcnt++;
      end
    end
    sa_b.arvalid = 1'b0;
`ifdef TAXI_AXI_PIPE_RD_LIMIT_EN
    chk("t6_limited_count", mcnt, 2);
    chk("t6_gated", ma_b.arvalid, 0);
    @(posedge clk); #1;
    ma_b.rvalid = 1'b1; ma_b.rlast = 1'b1; ma_b.rdata = 32'hE0;
    @(negedge clk);
    chk("t6_rlast_hs", ma_b.rready, 1);
    chk("t6_still_gated", ma_b.arvalid, 0);
    @(posedge clk); #1;
    ma_b.rvalid = 1'b0; ma_b.rlast = 1'b0;
    @(negedge clk);
    chk("t6_third_ar_valid", ma_b.arvalid, 1);
    chk("t6_third_ar_addr", ma_b.araddr, 32'h200);
    if (ma_b.arvalid && ma_b.arready) mcnt++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ma_b.arvalid && ma_b.arready) mcnt++;
    end
    chk("t6_total_after_release", mcnt, 3);
`else
    chk("t6_ungated_count", mcnt, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
